// File: rtl/nx1_video_pkg.sv
// Shared types and sizes for the X1 video-side VRAM fetch logic.
package nx1_video_pkg;

  localparam int unsigned VRAM_AW  = 11;
  localparam int unsigned CHR_W    = 8;
  localparam int unsigned PIPE_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [CHR_W-1:0] code;
    logic [CHR_W-1:0] attr;
  } chr_data_t;

endpackage

// File: rtl/nx1_fetch_pipe.sv
// Fixed-latency valid/last tag shift with data capture when the dpram output is due.
module nx1_fetch_pipe
  import nx1_video_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  logic      push_last,
  input  chr_data_t din,
  output logic      valid,
  output logic      last,
  output chr_data_t dout
);

  localparam int unsigned SR_W = PIPE_LAT - 1;

  logic [SR_W-1:0] v_sr;
  logic [SR_W-1:0] l_sr;

  // Tags travel alongside the address/RAM latency; a flush drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_sr  <= '0;
      l_sr  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      v_sr  <= {v_sr[SR_W-2:0], push};
      l_sr  <= {l_sr[SR_W-2:0], push & push_last};
      valid <= v_sr[SR_W-1];
      last  <= v_sr[SR_W-1] & l_sr[SR_W-1];
    end
  end

  // RAM data is valid in the cycle the oldest tag reaches the end of the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (v_sr[SR_W-1]) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/nx1_text_fetch.sv
// Text-VRAM fetch sequencer: walks each character row's addresses per scanline
// and tracks raster-within-row and row base across the frame.
module nx1_text_fetch
  import nx1_video_pkg::*;
#(
  parameter int unsigned RASTER_W = 5
) (
  input  logic                VCLK,
  input  logic                RESET,
  input  logic                FRAME_START,
  input  logic                LINE_START,
  input  logic                CE,
  input  logic [VRAM_AW-1:0]  START_ADDR,
  input  logic [CHR_W-1:0]    HDISP,
  input  logic [RASTER_W-1:0] RASTERS,
  output logic [VRAM_AW-1:0]  VA,
  input  logic [CHR_W-1:0]    VDO_TXT,
  input  logic [CHR_W-1:0]    VDO_ATR,
  output logic [CHR_W-1:0]    CHR_CODE,
  output logic [CHR_W-1:0]    CHR_ATTR,
  output logic                CHR_VALID,
  output logic                CHR_LAST,
  output logic [RASTER_W-1:0] RASTER,
  output logic                BUSY
);

  localparam int unsigned LE_W = VRAM_AW + RASTER_W;

  fetch_state_e        state_q, state_d;
  logic [VRAM_AW-1:0]  addr_q, addr_d;
  logic [VRAM_AW-1:0]  row_base_q, row_base_d;
  logic [VRAM_AW-1:0]  va_d;
  logic [CHR_W-1:0]    count_q, count_d;
  logic [RASTER_W-1:0] raster_d;
  logic                push, push_last, flush;
  chr_data_t           vdo, chr;

  // End-of-line bookkeeping: next raster, and advance the row base after the last raster.
  function automatic logic [LE_W-1:0] line_end(
    input logic [VRAM_AW-1:0]  base,
    input logic [RASTER_W-1:0] ras,
    input logic [RASTER_W-1:0] rasters,
    input logic [CHR_W-1:0]    hdisp
  );
    if (ras == rasters) begin
      return {base + VRAM_AW'(hdisp), {RASTER_W{1'b0}}};
    end
    return {base, ras + RASTER_W'(1)};
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    row_base_d = row_base_q;
    raster_d   = RASTER;
    va_d       = VA;
    push       = 1'b0;
    push_last  = 1'b0;
    flush      = 1'b0;

    if (FRAME_START) begin
      row_base_d = START_ADDR;
      raster_d   = '0;
      state_d    = ST_IDLE;
      flush      = 1'b1;
    end else if (state_q == ST_FETCH) begin
      if (LINE_START) begin
        // Aborted line still counts as a completed raster.
        {row_base_d, raster_d} = line_end(row_base_d, raster_d, RASTERS, HDISP);
      end else if (CE) begin
        va_d      = addr_q;
        addr_d    = addr_q + VRAM_AW'(1);
        count_d   = count_q + CHR_W'(1);
        push      = 1'b1;
        push_last = (count_q == HDISP - CHR_W'(1));
        if (push_last) begin
          {row_base_d, raster_d} = line_end(row_base_d, raster_d, RASTERS, HDISP);
          state_d = ST_DONE;
        end
      end
    end

    // A new line starts from whatever row base the updates above produced.
    if (LINE_START) begin
      addr_d  = row_base_d;
      count_d = '0;
      if (HDISP != '0) begin
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DONE;
        {row_base_d, raster_d} = line_end(row_base_d, raster_d, RASTERS, HDISP);
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge VCLK) begin
    if (RESET) begin
      addr_q     <= '0;
      count_q    <= '0;
      row_base_q <= '0;
      VA         <= '0;
      RASTER     <= '0;
      BUSY       <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      row_base_q <= row_base_d;
      VA         <= va_d;
      RASTER     <= raster_d;
      BUSY       <= (state_d == ST_FETCH);
    end
  end

  assign vdo = chr_data_t'{code: VDO_TXT, attr: VDO_ATR};

  nx1_fetch_pipe u_pipe (
    .clk       (VCLK),
    .rst       (RESET),
    .flush     (flush),
    .push      (push),
    .push_last (push_last),
    .din       (vdo),
    .valid     (CHR_VALID),
    .last      (CHR_LAST),
    .dout      (chr)
  );

  assign CHR_CODE = chr.code;
  assign CHR_ATTR = chr.attr;

endmodule

// File: tb/tb_nx1_text_fetch.sv
// Directed plus randomized bench for nx1_text_fetch against a behavioural
// line/row model and a registered-read VRAM model.
module tb_nx1_text_fetch;

  logic        VCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FRAME_START = 1'b0;
  logic        LINE_START = 1'b0;
  logic        CE = 1'b0;
  logic [10:0] START_ADDR = 11'h100;
  logic [7:0]  HDISP = 8'd40;
  logic [4:0]  RASTERS = 5'd7;
  logic [10:0] VA;
  logic [7:0]  VDO_TXT, VDO_ATR;
  logic [7:0]  CHR_CODE, CHR_ATTR;
  logic        CHR_VALID, CHR_LAST, BUSY;
  logic [4:0]  RASTER;

  always #5 VCLK = ~VCLK;

  nx1_text_fetch #(.RASTER_W(5)) dut (
    .VCLK        (VCLK),
    .RESET       (RESET),
    .FRAME_START (FRAME_START),
    .LINE_START  (LINE_START),
    .CE          (CE),
    .START_ADDR  (START_ADDR),
    .HDISP       (HDISP),
    .RASTERS     (RASTERS),
    .VA          (VA),
    .VDO_TXT     (VDO_TXT),
    .VDO_ATR     (VDO_ATR),
    .CHR_CODE    (CHR_CODE),
    .CHR_ATTR    (CHR_ATTR),
    .CHR_VALID   (CHR_VALID),
    .CHR_LAST    (CHR_LAST),
    .RASTER      (RASTER),
    .BUSY        (BUSY)
  );

  // Dual-port RAM V port: address registered at the clock, data out the cycle after.
  logic [7:0] txt_mem [2048];
  logic [7:0] atr_mem [2048];
  always @(posedge VCLK) begin
    VDO_TXT <= txt_mem[VA];
    VDO_ATR <= atr_mem[VA];
  end

  typedef struct {
    int       due;
    logic [7:0] code;
    logic [7:0] attr;
    bit       last;
  } exp_t;

  exp_t q[$];
  int   m_rb, m_ras, m_addr, m_count, m_va;
  bit   m_fetch;
  int   cyc, checks, errors, n_valid, n_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic m_line_end();
    if (m_ras == int'(RASTERS)) begin
      m_ras = 0;
      m_rb  = (m_rb + int'(HDISP)) % 2048;
    end else begin
      m_ras = m_ras + 1;
    end
  endtask

  task automatic model_update(input bit rst, input bit fs, input bit ls, input bit ce);
    exp_t e;
    if (rst) begin
      m_rb = 0; m_ras = 0; m_addr = 0; m_count = 0; m_va = 0; m_fetch = 0;
      q.delete();
    end else begin
      if (fs) begin
        m_rb = int'(START_ADDR); m_ras = 0; m_fetch = 0;
        q.delete();
      end else if (m_fetch) begin
        if (ls) begin
          m_line_end();
        end else if (ce) begin
          e.due  = cyc + 2;
          e.code = txt_mem[m_addr];
          e.attr = atr_mem[m_addr];
          e.last = (m_count == int'(HDISP) - 1);
          q.push_back(e);
          m_va    = m_addr;
          m_addr  = (m_addr + 1) % 2048;
          m_count = m_count + 1;
          if (e.last) begin
            m_line_end();
            m_fetch = 0;
          end
        end
      end
      if (ls) begin
        m_addr  = m_rb;
        m_count = 0;
        if (HDISP != 8'd0) m_fetch = 1;
        else begin
          m_fetch = 0;
          m_line_end();
        end
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("va", VA, m_va);
    chk("raster", RASTER, m_ras);
    chk("busy", BUSY, m_fetch);
    if (CHR_VALID === 1'b1) n_valid++;
    if (CHR_VALID === 1'b1 && CHR_LAST === 1'b1) n_last++;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("valid", CHR_VALID, 1);
      chk("code", CHR_CODE, e.code);
      chk("attr", CHR_ATTR, e.attr);
      chk("last", CHR_LAST, e.last);
    end else begin
      chk("valid_idle", CHR_VALID, 0);
    end
  endtask

  task automatic step(input bit fs, input bit ls, input bit ce);
    FRAME_START = fs;
    LINE_START  = ls;
    CE          = ce;
    @(posedge VCLK);
    cyc++;
    model_update(RESET, fs, ls, ce);
    @(negedge VCLK);
    check_outputs();
  endtask

  task automatic ce_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  task automatic gap_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_line(input int n_ce, input int gap);
    step(0, 1, 0);
    ce_steps(n_ce);
    gap_steps(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_va"}, VA, 0);
    chk({tag, "_code"}, CHR_CODE, 0);
    chk({tag, "_attr"}, CHR_ATTR, 0);
    chk({tag, "_valid"}, CHR_VALID, 0);
    chk({tag, "_last"}, CHR_LAST, 0);
    chk({tag, "_raster"}, RASTER, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      txt_mem[i] = 8'($urandom);
      atr_mem[i] = 8'($urandom);
    end
    cyc = 0; checks = 0; errors = 0;

    // Reset
    @(negedge VCLK);
    step(0, 0, 0);
    RESET = 1'b0;
    check_reset_outputs("rst");

    // Basic line
    step(1, 0, 0);
    n_valid = 0; n_last = 0;
    run_line(40, 4);
    chk("basic_nvalid", n_valid, 40);
    chk("basic_nlast", n_last, 1);
    chk("basic_raster", RASTER, 1);

    // Row advance: lines 2..8 reuse the row, line 9 moves on
    for (int l = 0; l < 7; l++) run_line(40, 4);
    chk("row8_raster", RASTER, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("row9_va", VA, 11'h128);
    chk("row9_raster", RASTER, 0);
    ce_steps(39);
    gap_steps(4);

    // Wrap at 7FF
    START_ADDR = 11'h7F0; HDISP = 8'd80; RASTERS = 5'd3;
    step(1, 0, 0);
    step(0, 1, 0);
    ce_steps(16);
    chk("wrap_va_hi", VA, 11'h7FF);
    step(0, 0, 1);
    chk("wrap_va_lo", VA, 11'h000);
    ce_steps(63);
    chk("wrap_va_end", VA, 11'h03F);
    gap_steps(4);
    for (int l = 0; l < 3; l++) run_line(80, 4);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("wrap_rowbase", VA, 11'h040);
    ce_steps(79);
    gap_steps(4);

    // Sparse CE then abort after 20 fetches
    START_ADDR = 11'h200; HDISP = 8'd40; RASTERS = 5'd7;
    step(1, 0, 0);
    step(0, 1, 0);
    n_valid = 0; n_last = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1);
      for (int k = 0; k < 7; k++) step(0, 0, 0);
    end
    chk("sparse_nvalid", n_valid, 20);
    chk("sparse_nlast", n_last, 0);
    chk("sparse_busy", BUSY, 1);
    step(0, 1, 0);
    chk("sparse_raster", RASTER, 1);
    step(0, 0, 1);
    chk("sparse_restart", VA, 11'h200);
    step(0, 0, 1);
    // Abort with fetches still in flight
    step(0, 1, 0);
    ce_steps(40);
    gap_steps(4);

    // HDISP = 0
    HDISP = 8'd0;
    step(1, 0, 0);
    n_valid = 0;
    step(0, 1, 0);
    chk("hd0_busy", BUSY, 0);
    chk("hd0_raster", RASTER, 1);
    gap_steps(5);
    step(0, 1, 1);
    chk("hd0_raster2", RASTER, 2);
    gap_steps(4);
    chk("hd0_nvalid", n_valid, 0);

    // Simultaneous FRAME_START + LINE_START
    START_ADDR = 11'h3A5; HDISP = 8'd10;
    step(1, 1, 0);
    chk("sim_raster", RASTER, 0);
    chk("sim_busy", BUSY, 1);
    step(0, 0, 1);
    chk("sim_va", VA, 11'h3A5);
    ce_steps(9);
    gap_steps(4);

    // Reset mid-line, then CE ignored until LINE_START
    START_ADDR = 11'h050;
    step(1, 0, 0);
    step(0, 1, 0);
    ce_steps(5);
    RESET = 1'b1;
    step(0, 0, 0);
    RESET = 1'b0;
    check_reset_outputs("midrst");
    n_valid = 0;
    ce_steps(5);
    chk("midrst_ign_va", VA, 0);
    chk("midrst_ign_valid", n_valid, 0);
    run_line(10, 4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit rfs, rls, rce;
      if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b1;
        step(0, 0, 0);
        RESET = 1'b0;
      end else begin
        rfs = ($urandom_range(0, 39) == 0);
        rls = ($urandom_range(0, 11) == 0);
        rce = rls ? 1'b0 : 1'($urandom_range(0, 1));
        if (rfs) begin
          START_ADDR = ($urandom_range(0, 2) == 0) ? 11'h7FA : 11'($urandom);
          HDISP      = 8'($urandom_range(0, 12));
          RASTERS    = 5'($urandom_range(0, 3));
        end
        step(rfs, rls, rce);
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
